image_loader: RTL and testbench

IMAGE_LOADER -- requirements
Module: image_loader

---
 rtl/image_loader_if.sv | 26 ++
 rtl/image_loader.sv | 153 +++++++++++++++
 tb/tb_image_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/image_loader_if.sv
// Bridge write port and image write-back port of the image loader, as one bundle.
// master = bridge/host side, slave = loader.
interface image_loader_if;
  logic        bridge_wr;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_wr_data;
  logic        overflow_clear;
  logic        background_write_en;
  logic        spritesheet_write_en;
  logic [16:0] image_write_addr;
  logic [15:0] image_write_data;
  logic        busy;
  logic        overflow;

  modport master (
    output bridge_wr, bridge_addr, bridge_wr_data, overflow_clear,
    input  background_write_en, spritesheet_write_en, image_write_addr,
           image_write_data, busy, overflow
  );

  modport slave (
    input  bridge_wr, bridge_addr, bridge_wr_data, overflow_clear,
    output background_write_en, spritesheet_write_en, image_write_addr,
           image_write_data, busy, overflow
  );
endinterface

// File: rtl/image_loader.sv
// Buffers 32-bit bridge words and serialises them into RGB565 pixel / alpha-byte writes.
// Write-to-first-strobe is 2 cycles, one beat per cycle; a word arriving at a full FIFO is dropped and flagged.
module image_loader #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned BG_PIXELS    = 129600,
  parameter int unsigned SPRITE_BYTES = 32768
) (
  input  logic         clk,
  input  logic         reset_n,
  image_loader_if.slave bus
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic        sprite;
    logic [17:0] addr;
    logic [31:0] dat;
  } entry_t;

  typedef struct packed {
    logic        en;
    logic [16:0] addr;
    logic [15:0] dat;
  } beat_t;

  typedef enum logic {IDLE, EMIT} state_t;

  // Beat address is kept at 18 bits so a +1/+3 past the top stays out of range instead of wrapping.
  function automatic beat_t beat_out(input logic sprite, input logic [17:0] base,
                                     input logic [31:0] dat, input logic [1:0] k);
    beat_t       b;
    logic [17:0] a;
    a      = base + {16'b0, k};
    b.addr = a[16:0];
    if (sprite) begin
      b.en = {14'b0, a} < SPRITE_BYTES;
      case (k)
        2'd0:    b.dat = {8'h00, dat[31:24]};
        2'd1:    b.dat = {8'h00, dat[23:16]};
        2'd2:    b.dat = {8'h00, dat[15:8]};
        default: b.dat = {8'h00, dat[7:0]};
      endcase
    end else begin
      b.en  = {14'b0, a} < BG_PIXELS;
      b.dat = k[0] ? dat[15:0] : dat[31:16];
    end
    return b;
  endfunction

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, next_count;
  state_t        state, next_state;
  logic [1:0]    beat;
  logic          cur_sprite;
  logic [17:0]   cur_base;
  logic [31:0]   cur_dat;

  logic          bg_en_q, sp_en_q, busy_q, overflow_q;
  logic [16:0]   addr_q;
  logic [15:0]   dat_q;

  logic          wr_valid, push, pop, drop, last_beat;
  entry_t        head, wr_entry;
  logic [17:0]   head_base;
  beat_t         nxt_beat;
  logic          nxt_sprite;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bus.bridge_addr[27:18];

  assign wr_valid  = bus.bridge_wr &&
                     (bus.bridge_addr[31:28] == 4'h1 || bus.bridge_addr[31:28] == 4'h2);
  assign wr_entry  = '{sprite: (bus.bridge_addr[31:28] == 4'h2),
                       addr:   bus.bridge_addr[17:0],
                       dat:    bus.bridge_wr_data};
  assign head      = mem[rd_ptr];
  assign head_base = head.sprite ? {3'b0, head.addr[14:0]} : {1'b0, head.addr[17:1]};

  always_comb begin
    last_beat  = (beat == (cur_sprite ? 2'd3 : 2'd1));
    pop        = (count != '0) && (state == IDLE || last_beat);
    push       = wr_valid && ((count != FULL_CNT) || pop);
    drop       = wr_valid && (count == FULL_CNT) && !pop;
    next_count = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    if (pop)                              next_state = EMIT;
    else if (state == EMIT && !last_beat) next_state = EMIT;
    else                                  next_state = IDLE;
    nxt_sprite = pop ? head.sprite : cur_sprite;
    nxt_beat   = pop ? beat_out(head.sprite, head_base, head.dat, 2'd0)
                     : beat_out(cur_sprite, cur_base, cur_dat, beat + 2'd1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      beat       <= 2'd0;
      cur_sprite <= 1'b0;
      cur_base   <= '0;
      cur_dat    <= '0;
      bg_en_q    <= 1'b0;
      sp_en_q    <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= next_count;
      state      <= next_state;
      busy_q     <= (next_count != '0) || (next_state == EMIT);
      // A drop in the same cycle as a clear must leave the flag set.
      overflow_q <= drop || (overflow_q && !bus.overflow_clear);

      if (pop) begin
        cur_sprite <= head.sprite;
        cur_base   <= head_base;
        cur_dat    <= head.dat;
        beat       <= 2'd0;
      end else if (state == EMIT && !last_beat) begin
        beat <= beat + 2'd1;
      end

      if (next_state == EMIT) begin
        bg_en_q <= nxt_beat.en && !nxt_sprite;
        sp_en_q <= nxt_beat.en && nxt_sprite;
        addr_q  <= nxt_beat.addr;
        dat_q   <= nxt_beat.dat;
      end else begin
        bg_en_q <= 1'b0;
        sp_en_q <= 1'b0;
      end
    end
  end

  assign bus.background_write_en  = bg_en_q;
  assign bus.spritesheet_write_en = sp_en_q;
  assign bus.image_write_addr     = addr_q;
  assign bus.image_write_data     = dat_q;
  assign bus.busy                 = busy_q;
  assign bus.overflow             = overflow_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: each task drives one scenario and checks hand-computed values.
module tb_image_loader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  image_loader_if bus ();

  image_loader #(.FIFO_DEPTH(4), .BG_PIXELS(129600), .SPRITE_BYTES(32768)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Each "cycle" starts 1 time unit after a rising edge: outputs are sampled and inputs driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.bridge_wr = 0; bus.bridge_addr = 0; bus.bridge_wr_data = 0; bus.overflow_clear = 0;
    reset_n = 0;
    tick(); tick();
    checks++; if (bus.background_write_en !== 1'b0 || bus.spritesheet_write_en !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b exp 00", bus.background_write_en, bus.spritesheet_write_en); end
    checks++; if (bus.image_write_addr !== 17'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.image_write_addr); end
    checks++; if (bus.image_write_data !== 16'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.image_write_data); end
    checks++; if (bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got busy %b ovf %b exp 0 0", bus.busy, bus.overflow); end
    reset_n = 1;
    tick();
  endtask

  task automatic test_bg_single();
    tick();
    bus.bridge_wr = 1; bus.bridge_addr = 32'h1000_0010; bus.bridge_wr_data = 32'hF800_07E0;
    tick();
    bus.bridge_wr = 0;
    checks++; if (bus.background_write_en !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL bg_cycle1 got en %b busy %b exp 0 1", bus.background_write_en, bus.busy); end
    tick();
    checks++; if (bus.background_write_en !== 1'b1 || bus.spritesheet_write_en !== 1'b0) begin errors++; $display("FAIL bg_beat0_en got %b%b exp 10", bus.background_write_en, bus.spritesheet_write_en); end
    checks++; if (bus.image_write_addr !== 17'd8 || bus.image_write_data !== 16'hF800) begin errors++; $display("FAIL bg_beat0 got %0d/%h exp 8/f800", bus.image_write_addr, bus.image_write_data); end
    tick();
    checks++; if (bus.background_write_en !== 1'b1 || bus.image_write_addr !== 17'd9 || bus.image_write_data !== 16'h07E0) begin errors++; $display("FAIL bg_beat1 got %b %0d/%h exp 1 9/07e0", bus.background_write_en, bus.image_write_addr, bus.image_write_data); end
    tick();
    checks++; if (bus.background_write_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL bg_done got en %b busy %b exp 0 0", bus.background_write_en, bus.busy); end
  endtask

  task automatic test_sprite_single();
    logic [31:0] w;
    w = 32'h1122_3344;
    tick();
    bus.bridge_wr = 1; bus.bridge_addr = 32'h2000_0100; bus.bridge_wr_data = w;
    tick();
    bus.bridge_wr = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.spritesheet_write_en !== 1'b1 || bus.background_write_en !== 1'b0 ||
          bus.image_write_addr !== 17'(256 + k) || bus.image_write_data !== {8'h00, w[31-8*k -: 8]}) begin
        errors++;
        $display("FAIL sprite_beat%0d got sp %b bg %b %0d/%h exp 1 0 %0d/%h", k, bus.spritesheet_write_en,
                 bus.background_write_en, bus.image_write_addr, bus.image_write_data, 256 + k, {8'h00, w[31-8*k -: 8]});
      end
    end
    tick();
    checks++; if (bus.spritesheet_write_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL sprite_done got en %b busy %b exp 0 0", bus.spritesheet_write_en, bus.busy); end
  endtask

  task automatic test_bounds();
    tick();
    bus.bridge_wr = 1; bus.bridge_addr = 32'h1003_F47E; bus.bridge_wr_data = 32'hABCD_1234;
    tick();
    bus.bridge_wr = 0;
    tick();
    checks++; if (bus.background_write_en !== 1'b1 || bus.image_write_addr !== 17'd129599 || bus.image_write_data !== 16'hABCD) begin errors++; $display("FAIL bounds_beat0 got %b %0d/%h exp 1 129599/abcd", bus.background_write_en, bus.image_write_addr, bus.image_write_data); end
    tick();
    checks++; if (bus.background_write_en !== 1'b0 || bus.spritesheet_write_en !== 1'b0) begin errors++; $display("FAIL bounds_beat1_suppressed got %b%b exp 00", bus.background_write_en, bus.spritesheet_write_en); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bounds_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_invalid();
    tick();
    bus.bridge_wr = 1; bus.bridge_addr = 32'h3000_0000; bus.bridge_wr_data = 32'hDEAD_BEEF;
    tick();
    bus.bridge_wr = 0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus.background_write_en !== 1'b0 || bus.spritesheet_write_en !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
        errors++;
        $display("FAIL invalid_c%0d got bg %b sp %b busy %b ovf %b exp 0 0 0 0", c, bus.background_write_en,
                 bus.spritesheet_write_en, bus.busy, bus.overflow);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    // bg pixel 16..17 then sprite bytes 64..67, with no idle cycle between the words.
    logic        exp_bg  [6];
    logic [16:0] exp_adr [6];
    logic [15:0] exp_dat [6];
    exp_bg  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_adr = '{17'd16, 17'd17, 17'd64, 17'd65, 17'd66, 17'd67};
    exp_dat = '{16'h1111, 16'h2222, 16'h0055, 16'h0066, 16'h0077, 16'h0088};
    tick();
    bus.bridge_wr = 1; bus.bridge_addr = 32'h1000_0020; bus.bridge_wr_data = 32'h1111_2222;
    tick();
    bus.bridge_addr = 32'h2000_0040; bus.bridge_wr_data = 32'h5566_7788;
    tick();
    bus.bridge_wr = 0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.background_write_en !== exp_bg[i] || bus.spritesheet_write_en !== !exp_bg[i] ||
          bus.image_write_addr !== exp_adr[i] || bus.image_write_data !== exp_dat[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d got bg %b sp %b %0d/%h exp bg %b %0d/%h", i, bus.background_write_en,
                 bus.spritesheet_write_en, bus.image_write_addr, bus.image_write_data, exp_bg[i], exp_adr[i], exp_dat[i]);
      end
      tick();
    end
    checks++; if (bus.busy !== 1'b0 || bus.spritesheet_write_en !== 1'b0) begin errors++; $display("FAIL b2b_done got busy %b sp %b exp 0 0", bus.busy, bus.spritesheet_write_en); end
  endtask

  task automatic test_overflow();
    // Sprite words in cycles 0..6. The word in cycle 5 meets a full FIFO on the same cycle
    // the first word's last beat pops, so it is kept; the cycle-6 word is the one dropped.
    // overflow_clear is held during the drop cycle: the drop must still win.
    int          strobes = 0;
    logic [16:0] last_addr = '0;
    logic [15:0] last_dat = '0;
    logic        done = 1'b0;
    tick();
    for (int c = 0; c < 80 && !done; c++) begin
      if (bus.spritesheet_write_en === 1'b1) begin
        strobes++;
        last_addr = bus.image_write_addr;
        last_dat  = bus.image_write_data;
      end
      if (bus.background_write_en !== 1'b0) begin
        checks++; errors++;
        $display("FAIL ovf_bg_strobe got %b exp 0 at c%0d", bus.background_write_en, c);
      end
      if (c == 7) begin
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.overflow); end
      end
      if (c > 8 && bus.busy === 1'b0) done = 1'b1;
      bus.bridge_wr      = (c < 7);
      bus.bridge_addr    = 32'h2000_0000 + 32'(16 * c);
      bus.bridge_wr_data = {4{8'(c)}};
      bus.overflow_clear = (c == 6);
      tick();
    end
    bus.bridge_wr = 0; bus.overflow_clear = 0;
    checks++; if (!done) begin errors++; $display("FAIL ovf_timeout got busy %b exp 0 within 80 cycles", bus.busy); end
    checks++; if (strobes != 24) begin errors++; $display("FAIL ovf_strobes got %0d exp 24", strobes); end
    checks++; if (last_addr !== 17'd83 || last_dat !== 16'h0005) begin errors++; $display("FAIL ovf_last_word got %0d/%h exp 83/0005", last_addr, last_dat); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow); end
    bus.overflow_clear = 1;
    tick();
    bus.overflow_clear = 0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    tick();
    bus.bridge_wr = 1; bus.bridge_addr = 32'h2000_0100; bus.bridge_wr_data = 32'h1122_3344;
    tick();
    bus.bridge_wr = 0;
    tick();
    tick();
    checks++; if (bus.spritesheet_write_en !== 1'b1 || bus.image_write_addr !== 17'd257) begin errors++; $display("FAIL mid_beat1 got %b %0d exp 1 257", bus.spritesheet_write_en, bus.image_write_addr); end
    reset_n = 0;
    #1;
    checks++; if (bus.spritesheet_write_en !== 1'b0 || bus.image_write_addr !== 17'd0 || bus.image_write_data !== 16'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got sp %b %0d/%h busy %b exp 0 0/0000 0", bus.spritesheet_write_en,
               bus.image_write_addr, bus.image_write_data, bus.busy);
    end
    tick(); tick();
    reset_n = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.spritesheet_write_en !== 1'b0 || bus.background_write_en !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL mid_no_stray_beats got %0d strobes exp 0", stray); end
    test_bg_single();
  endtask

  initial begin
    test_reset();
    test_bg_single();
    test_sprite_single();
    test_bounds();
    test_invalid();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
